freq_meter: RTL and testbench

- Parametrised gated frequency counter, single `ref_clk` domain.
- Synchronises the asynchronous `unknown` input and counts its rising edges over a programmable gate window of `ref_clk` cycles.
- Latches each result with a one-cycle valid pulse and a saturation flag.
- Supports single-shot and gapless continuous operation; feeds the display/readout logic as the successor of the simple edge counter.

---
 rtl/freq_meter.sv | 188 ++++++++++++++++++
 tb/tb_freq_meter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated frequency counter: synchronises an asynchronous input, counts its
// rising edges over a programmable window of ref_clk cycles and publishes
// each result with a one-cycle valid pulse and a saturation flag.
// Single-shot (start) or gapless continuous (cont) operation.
// Optional macro FREQ_METER_PERIOD_EN adds edge-to-edge period measurement
// on the period / period_valid outputs.
module freq_meter #(
    parameter int CNT_W       = 24,
    parameter int GATE_W      = 32,
    parameter int GATE_CYCLES = 100000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic              ref_clk,
    input  logic              rst_n,
    input  logic              unknown,
    input  logic              start,
    input  logic              cont,
    output logic              busy,
    output logic [CNT_W-1:0]  count,
    output logic              count_valid,
    output logic              overflow
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [GATE_W-1:0] period,
    output logic              period_valid
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } state_t;

    localparam logic [GATE_W-1:0] TIMER_TERM = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GATE_W-1:0] TIMER_ZERO = {GATE_W{1'b0}};
    localparam logic [GATE_W-1:0] TIMER_ONE  = {{(GATE_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic                   w_edge;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [GATE_W-1:0]      r_timer;
    logic [GATE_W-1:0]      w_timer_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic                   r_sat;
    logic                   w_sat_nxt;
    logic                   w_sat_hit;
    logic                   w_cnt_full;
    logic                   w_term;
    logic                   w_publish;

    // Synchronise the asynchronous input and keep one delayed copy for edge detection
    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            r_sync   <= {SYNC_STAGES{1'b0}};
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], unknown};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_sync_d;
    assign w_cnt_full = (r_cnt == CNT_MAX);
    assign w_sat_hit  = w_cnt_full & w_edge;
    assign w_term     = (r_state == ST_GATE) && (r_timer == TIMER_TERM);

    // Saturating edge-counter increment; an edge on the terminal cycle is included
    always_comb begin
        w_cnt_inc = r_cnt;
        if (w_edge && !w_cnt_full) begin
            w_cnt_inc = r_cnt + CNT_ONE;
        end else begin
            w_cnt_inc = r_cnt;
        end
    end

    // Next-state logic for the gate FSM, timer and edge accumulator
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_cnt_nxt   = r_cnt;
        w_sat_nxt   = r_sat;
        w_publish   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start || cont) begin
                    w_state_nxt = ST_GATE;
                    w_timer_nxt = TIMER_ZERO;
                    w_cnt_nxt   = CNT_ZERO;
                    w_sat_nxt   = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GATE: begin
                if (w_term) begin
                    // Reload on the terminal edge so a continuous run has no dead time
                    w_publish   = 1'b1;
                    w_timer_nxt = TIMER_ZERO;
                    w_cnt_nxt   = CNT_ZERO;
                    w_sat_nxt   = 1'b0;
                    w_state_nxt = cont ? ST_GATE : ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TIMER_ONE;
                    w_cnt_nxt   = w_cnt_inc;
                    w_sat_nxt   = r_sat | w_sat_hit;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = TIMER_ZERO;
                w_cnt_nxt   = CNT_ZERO;
                w_sat_nxt   = 1'b0;
            end
        endcase
    end

    // State register, gate timer and edge accumulator
    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_timer <= TIMER_ZERO;
            r_cnt   <= CNT_ZERO;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    // Registered status and published result; count/overflow hold between windows
    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            count       <= CNT_ZERO;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            busy        <= (w_state_nxt == ST_GATE);
            count_valid <= w_publish;
            if (w_publish) begin
                count    <= w_cnt_inc;
                overflow <= r_sat | w_sat_hit;
            end
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    localparam logic [GATE_W-1:0] PER_MAX = {GATE_W{1'b1}};

    logic [GATE_W-1:0] r_per_cnt;
    logic              r_armed;

    // Edge-to-edge period measurement, independent of the gate FSM
    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            r_per_cnt    <= TIMER_ZERO;
            r_armed      <= 1'b0;
            period       <= TIMER_ZERO;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (w_edge) begin
                // The first edge after reset only arms the measurement
                r_per_cnt <= TIMER_ONE;
                r_armed   <= 1'b1;
                if (r_armed) begin
                    period       <= r_per_cnt;
                    period_valid <= 1'b1;
                end
            end else if (r_per_cnt != PER_MAX) begin
                r_per_cnt <= r_per_cnt + TIMER_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter (CNT_W=4, GATE_CYCLES=100).
// Expected window results come from a sample-history model: every value of
// `unknown` seen at a ref_clk edge is logged, and a window's count is the
// number of logged 0->1 transitions falling inside that window's sample span.
module tb_freq_meter;

    localparam int GATE = 100;
    localparam int SYNC = 2;
    localparam int CMAX = 15;
    localparam int MAXC = 20000;

    logic        ref_clk;
    logic        rst_n;
    logic        unknown;
    logic        start;
    logic        cont;
    logic        busy;
    logic [3:0]  count;
    logic        count_valid;
    logic        overflow;
`ifdef FREQ_METER_PERIOD_EN
    logic [31:0] period;
    logic        period_valid;
`endif

    int   n_asserts = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    bit   u_s [0:MAXC];
    int   mode      = 0;
    int   per       = 10;
    logic man_u     = 1'b0;
    bit   got;
    int   s;
    int   r;
    int   busy_n;
    int   nv;
    int   nb;

    freq_meter #(
        .CNT_W(4), .GATE_W(32), .GATE_CYCLES(GATE), .SYNC_STAGES(SYNC)
    ) dut (
        .ref_clk(ref_clk), .rst_n(rst_n), .unknown(unknown), .start(start),
        .cont(cont), .busy(busy), .count(count), .count_valid(count_valid),
        .overflow(overflow)
`ifdef FREQ_METER_PERIOD_EN
        , .period(period), .period_valid(period_valid)
`endif
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    // Log the input value seen at each sampling edge
    always @(posedge ref_clk) begin
        cyc = cyc + 1;
        if (cyc <= MAXC) u_s[cyc] = unknown;
    end

    // Input generator: 0 = manual, 1 = square wave of period `per`, 2 = random phases
    initial begin
        int ph;
        int hold;
        ph = 0;
        hold = 0;
        unknown = 1'b0;
        forever begin
            @(negedge ref_clk);
            #2;
            case (mode)
                0: unknown = man_u;
                1: begin
                    unknown = (ph < per / 2);
                    ph = (ph >= per - 1) ? 0 : ph + 1;
                end
                default: begin
                    if (hold == 0) begin
                        unknown = ~unknown;
                        hold = $urandom_range(11, 0);
                    end else begin
                        hold = hold - 1;
                    end
                end
            endcase
        end
    end

    // Rising edges sampled in the window whose start pulse was taken at edge s0
    function automatic int rises(input int s0);
        int k;
        k = 0;
        for (int n = s0 + 1 - SYNC; n <= s0 + GATE - SYNC; n++)
            if (u_s[n] && !u_s[n-1]) k++;
        return k;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge ref_clk);
            if (count_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("valid_seen", 32'(got), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        s = cyc + 1;
        @(negedge ref_clk);
        start = 1'b0;
    endtask

    task automatic check_window(input string tag, input int s0);
        r = rises(s0);
        check({tag, "_cnt"}, 32'(count), (r > CMAX) ? 32'(CMAX) : 32'(r));
        check({tag, "_ovf"}, 32'(overflow), (r > CMAX) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        mode  = 2;

        // Reset with the input toggling
        repeat (3) @(negedge ref_clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(count_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // Single shot, square period 10, extra start while busy
        mode = 1;
        per  = 10;
        repeat (20) @(negedge ref_clk);
        start = 1'b1;
        s = cyc + 1;
        busy_n = 0;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge ref_clk);
            start = (i == 50);
            if (count_valid) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_n++;
        end
        start = 1'b0;
        check("ss_valid_seen", 32'(got), 32'd1);
        check("ss_latency", 32'(cyc), 32'(s + GATE));
        check("ss_busy_len", 32'(busy_n), 32'd100);
        check("ss_count10", 32'(count), 32'd10);
        check_window("ss", s);
        check("ss_busy_end", 32'(busy), 32'd0);
        @(negedge ref_clk);
        check("ss_pulse_w", 32'(count_valid), 32'd0);
        nv = 0;
        nb = 0;
        repeat (150) begin
            @(negedge ref_clk);
            if (count_valid) nv++;
            if (busy) nb++;
        end
        check("ss_no_extra_valid", 32'(nv), 32'd0);
        check("ss_no_extra_busy", 32'(nb), 32'd0);

        // Continuous windows with random input, then drop cont mid-window
        mode = 2;
        repeat (5) @(negedge ref_clk);
        cont = 1'b1;
        s = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(250);
            check("ct_spacing", 32'(cyc), 32'(s + GATE * (k + 1)));
            check_window("ct", s + GATE * k);
            check("ct_busy", 32'(busy), 32'd1);
        end
        repeat (30) @(negedge ref_clk);
        cont = 1'b0;
        wait_valid(250);
        check("ct_last_spacing", 32'(cyc), 32'(s + GATE * 5));
        check_window("ct_last", s + GATE * 4);
        @(negedge ref_clk);
        check("ct_idle_busy", 32'(busy), 32'd0);
        nv = 0;
        repeat (150) begin
            @(negedge ref_clk);
            if (count_valid) nv++;
        end
        check("ct_no_more_valid", 32'(nv), 32'd0);

        // Saturation, then recovery
        mode = 1;
        per  = 2;
        repeat (10) @(negedge ref_clk);
        pulse_start();
        wait_valid(250);
        check("sat_count", 32'(count), 32'd15);
        check("sat_ovf", 32'(overflow), 32'd1);
        check_window("sat", s);
        per = 10;
        repeat (20) @(negedge ref_clk);
        pulse_start();
        wait_valid(250);
        check("rec_count", 32'(count), 32'd10);
        check("rec_ovf", 32'(overflow), 32'd0);
        check_window("rec", s);

        // Edge registered on the terminal cycle belongs to the window
        mode  = 0;
        man_u = 1'b0;
        repeat (10) @(negedge ref_clk);
        pulse_start();
        while (cyc < s + GATE - SYNC - 1) @(negedge ref_clk);
        man_u = 1'b1;
        wait_valid(250);
        check("term_edge_in", 32'(count), 32'd1);
        check_window("term_in", s);
        man_u = 1'b0;
        repeat (10) @(negedge ref_clk);

        // First counted sample included, one past the terminal excluded
        man_u = 1'b1;
        @(negedge ref_clk);
        start = 1'b1;
        s = cyc + 1;
        @(negedge ref_clk);
        start = 1'b0;
        man_u = 1'b0;
        while (cyc < s + GATE - SYNC) @(negedge ref_clk);
        man_u = 1'b1;
        wait_valid(250);
        check("edge_bounds", 32'(count), 32'd1);
        check_window("bounds", s);
        man_u = 1'b0;
        repeat (10) @(negedge ref_clk);

        // Reset mid-window: no result, count cleared and held
        mode = 2;
        repeat (10) @(negedge ref_clk);
        pulse_start();
        repeat (50) @(negedge ref_clk);
        rst_n = 1'b0;
        repeat (3) @(negedge ref_clk);
        rst_n = 1'b1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_count", 32'(count), 32'd0);
        nv = 0;
        repeat (200) begin
            @(negedge ref_clk);
            if (count_valid) nv++;
        end
        check("mrst_no_valid", 32'(nv), 32'd0);
        check("mrst_count_held", 32'(count), 32'd0);

`ifdef FREQ_METER_PERIOD_EN
        // Period measurement on a period-10 square wave
        mode  = 0;
        man_u = 1'b0;
        repeat (5) @(negedge ref_clk);
        rst_n = 1'b0;
        repeat (3) @(negedge ref_clk);
        check("per_rst_val", period, 32'd0);
        check("per_rst_valid", 32'(period_valid), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge ref_clk);
        mode = 1;
        per  = 10;
        begin
            int last;
            int np;
            last = -1;
            np = 0;
            repeat (120) begin
                @(negedge ref_clk);
                if (period_valid) begin
                    np++;
                    check("per_value", period, 32'd10);
                    if (last >= 0) check("per_spacing", 32'(cyc - last), 32'd10);
                    last = cyc;
                end
            end
            check("per_pulses", (np >= 10) ? 32'd1 : 32'd0, 32'd1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
